pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline. Sits beside the ID stage.
- Detects load-use hazards that forwarding cannot cover.
- Issues multiply/divide operations to an iterative HI/LO unit and tracks its occupancy with an FSM and counter.
- Drives the PC/IF-ID write enable and the ID/EX bubble injection.

Parameters:
- MUL_CYCLES, 4: busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 32: busy cycles for div/divu; must be ≥1.
- CNT_W, 6: occupancy counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clock  in  1  pipeline clock; rising edge.
- resetn  in  1  asynchronous active-low reset.
- id_rs  in  5  inst[25:21] of the ID instruction.
- id_rt  in  5  inst[20:16] of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ern  in  5  EX-stage destination register.
- ewreg  in  1  EX-stage writes a register.
- em2reg  in  1  EX-stage instruction is a load.
- id_md  in  1  ID holds mult/multu/div/divu.
- id_md_div  in  1  1 = divide, 0 = multiply (valid with id_md).
- id_hilo_rd  in  1  ID holds mfhi/mflo.
- wpcir  out  1  1 = PC and IF/ID register advance; 0 = hold.
- dbubble  out  1  1 = ID/EX register loads a NOP (wreg/wmem cleared).
- md_start  out  1  single-cycle issue strobe to the HI/LO unit.
- md_busy  out  1  HI/LO unit occupied.
- md_done  out  1  HI/LO results valid this cycle.
- md_count  out  CNT_W  remaining busy cycles.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, md_count=0.
  - Outputs forced: md_busy=0, md_done=0, md_start=0, wpcir=1, dbubble=0, regardless of other inputs.
- lu_haz = ewreg & em2reg & (ern≠0) & ((id_use_rs & ern==id_rs) | (id_use_rt & ern==id_rt)).
  - Register $0 never causes a stall.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if issue → BUSY, md_count←(id_md_div ? DIV_CYCLES : MUL_CYCLES).
  - BUSY: md_count decrements each cycle. When md_count==1, next state is DONE with md_count←0.
  - DONE: lasts one cycle. If issue → BUSY (reload); else → IDLE.
- issue = id_md & ~lu_haz & (state∈{IDLE, DONE}). md_start = issue (combinational, same cycle).
- md_haz = (state==BUSY) & (id_md | id_hilo_rd). mfhi/mflo and a new md op proceed in DONE.
- stall = lu_haz | md_haz. wpcir = ~stall, dbubble = stall.
  - Stall is combinational from current inputs and state.
- md_busy = (state==BUSY); md_done = (state==DONE).
- Latency:
  - Issue sampled at edge ending cycle T.
  - BUSY during T+1..T+N; DONE at T+N+1 (N = MUL_CYCLES or DIV_CYCLES).
- Simultaneous events:
  - lu_haz blocks issue; the md op issues the cycle after the load leaves EX.
  - Both hazards active gives a single stall; no double bubble.
- Non-md instructions not reading HI/LO flow freely while BUSY.
- Reset mid-BUSY aborts the operation: no md_done is produced.

Optional Feature:
- Macro STALL_STATS_EN.
- When defined, adds outputs lu_stall_cnt[31:0] and md_stall_cnt[31:0]. Each increments on a cycle where lu_haz, respectively md_haz, is 1. Both may increment in the same cycle. Both wrap at 2^32 and clear on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - MUL_CYCLES/DIV_CYCLES defaults.
  - Register-zero constant.
- One sub-module, md_occupancy: FSM plus counter, producing md_busy, md_done, md_count.
- Hazard compare and stall logic stay in the top level.

Test Plan:
- Reset values: ern=5, ewreg=1, em2reg=1, id_rs=5, id_use_rs=1 with resetn=0 → wpcir=1, dbubble=0, md_busy=0, md_count=0.
- Load-use: lw $5 in EX (ern=5, ewreg=1, em2reg=1), ID uses rt=5 → wpcir=0 and dbubble=1 for exactly one cycle. Same case with ern=0 → no stall.
- Multiply: id_md=1, id_md_div=0 in IDLE → md_start=1 for one cycle, md_busy=1 for 4 cycles (md_count 4,3,2,1), md_done=1 on cycle 5, then IDLE.
- HI/LO read stall: divide issued at T, mfhi in ID at T+1 → stall for 32 cycles, wpcir=1 at T+33 (DONE).
- Back-to-back: second mult in ID during BUSY stalls until DONE. md_start fires in DONE and md_count reloads to 4 with no IDLE cycle.
- Abort: resetn pulsed low at md_count=10 → immediately IDLE, md_busy=0, md_done never asserted. With STALL_STATS_EN, counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam int unsigned REG_W          = 5;
    localparam int unsigned MUL_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF = 32;
    localparam int unsigned CNT_W_DEF      = 6;
    localparam int unsigned STAT_W         = 32;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ID/EX hazard inputs and stall/HI-LO status outputs of the stall sequencer.
// Stall counters exist only when STALL_STATS_EN is defined.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CNT_W = pipe_pkg::CNT_W_DEF
);
    logic [pipe_pkg::REG_W-1:0] id_rs;
    logic [pipe_pkg::REG_W-1:0] id_rt;
    logic                       id_use_rs;
    logic                       id_use_rt;
    logic [pipe_pkg::REG_W-1:0] ern;
    logic                       ewreg;
    logic                       em2reg;
    logic                       id_md;
    logic                       id_md_div;
    logic                       id_hilo_rd;
    logic                       wpcir;
    logic                       dbubble;
    logic                       md_start;
    logic                       md_busy;
    logic                       md_done;
    logic [CNT_W-1:0]           md_count;
`ifdef STALL_STATS_EN
    logic [pipe_pkg::STAT_W-1:0] lu_stall_cnt;
    logic [pipe_pkg::STAT_W-1:0] md_stall_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ern, ewreg, em2reg,
               id_md, id_md_div, id_hilo_rd,
        input  wpcir, dbubble, md_start, md_busy, md_done, md_count
`ifdef STALL_STATS_EN
      , input  lu_stall_cnt, md_stall_cnt
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ern, ewreg, em2reg,
               id_md, id_md_div, id_hilo_rd,
        output wpcir, dbubble, md_start, md_busy, md_done, md_count
`ifdef STALL_STATS_EN
      , output lu_stall_cnt, md_stall_cnt
`endif
    );

endinterface

// File: rtl/md_occupancy.sv
// Occupancy tracker for the iterative HI/LO unit: IDLE/BUSY/DONE FSM with a
// remaining-cycle counter.
module md_occupancy
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             issue,
    input  logic             md_div,
    output md_state_e        state,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] md_count
);

    md_state_e        state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] load_val;

    // State and counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            md_count <= '0;
        end else begin
            state    <= state_nxt;
            md_count <= count_nxt;
        end
    end

    // Next state and counter; DONE may reload directly into BUSY
    always_comb begin
        state_nxt = state;
        count_nxt = md_count;
        load_val  = md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = BUSY;
                    count_nxt = load_val;
                end
            end
            BUSY: begin
                if (md_count == CNT_W'(1)) begin
                    state_nxt = DONE;
                    count_nxt = '0;
                end else begin
                    count_nxt = md_count - CNT_W'(1);
                end
            end
            DONE: begin
                if (issue) begin
                    state_nxt = BUSY;
                    count_nxt = load_val;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Status decode
    always_comb begin
        md_busy = 1'b0;
        md_done = 1'b0;
        md_busy = (state == BUSY);
        md_done = (state == DONE);
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Load-use and HI/LO hazard detection with PC/IF-ID hold and ID/EX bubble.
// Optional stall statistics counters under STALL_STATS_EN.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    pipe_stall_ctrl_if.slave  bus
);

    md_state_e state;
    logic      rs_hit;
    logic      rt_hit;
    logic      lu_haz;
    logic      md_haz;
    logic      issue;
    logic      stall;
    logic      md_busy;
    logic      md_done;
    logic [CNT_W-1:0] md_count;

    // Hazard detection; reset forces the pipeline to advance with no issue
    always_comb begin
        rs_hit = bus.id_use_rs && (bus.ern == bus.id_rs);
        rt_hit = bus.id_use_rt && (bus.ern == bus.id_rt);
        lu_haz = bus.ewreg && bus.em2reg && (bus.ern != REG_ZERO) && (rs_hit || rt_hit);
        md_haz = (state == BUSY) && (bus.id_md || bus.id_hilo_rd);
        issue  = resetn && bus.id_md && !lu_haz && ((state == IDLE) || (state == DONE));
        stall  = resetn && (lu_haz || md_haz);
    end

    assign bus.md_start = issue;
    assign bus.wpcir    = !stall;
    assign bus.dbubble  = stall;
    assign bus.md_busy  = md_busy;
    assign bus.md_done  = md_done;
    assign bus.md_count = md_count;

    md_occupancy #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_occupancy (
        .clock    (clock),
        .resetn   (resetn),
        .issue    (issue),
        .md_div   (bus.id_md_div),
        .state    (state),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .md_count (md_count)
    );

`ifdef STALL_STATS_EN
    logic [STAT_W-1:0] lu_cnt;
    logic [STAT_W-1:0] md_cnt;

    // Free-running hazard cycle counters, wrap naturally
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lu_cnt <= '0;
            md_cnt <= '0;
        end else begin
            if (lu_haz) lu_cnt <= lu_cnt + STAT_W'(1);
            if (md_haz) md_cnt <= md_cnt + STAT_W'(1);
        end
    end

    assign bus.lu_stall_cnt = lu_cnt;
    assign bus.md_stall_cnt = md_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: cycle model plus directed literals.
module tb_pipe_stall_ctrl;
    import pipe_pkg::*;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    pipe_stall_ctrl_if #(.CNT_W(6)) bus ();

    pipe_stall_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (6)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an op issued in cycle T is busy in T+1..T+N and done in T+N+1
    int   cyc = 0;
    int   issue_cyc = -1000;
    int   issue_n = 0;
    logic m_lu;
    logic m_md;
    logic m_issue = 1'b0;
    int   lu_m = 0;
    int   md_m = 0;
    int   done_seen = 0;
    logic abort_watch = 1'b0;

    always @(negedge clock) begin
        logic busy, done, stall;
        int   cnt;
        if (!resetn) begin
            issue_cyc = -1000;
            lu_m = 0;
            md_m = 0;
        end
        busy = (cyc > issue_cyc) && (cyc <= issue_cyc + issue_n);
        done = (cyc == issue_cyc + issue_n + 1);
        cnt  = busy ? (issue_cyc + issue_n - cyc + 1) : 0;
        m_lu = bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
               ((bus.id_use_rs && bus.ern == bus.id_rs) || (bus.id_use_rt && bus.ern == bus.id_rt));
        m_md = busy && (bus.id_md || bus.id_hilo_rd);
        stall = resetn && (m_lu || m_md);
        m_issue = resetn && bus.id_md && !m_lu && !busy;
        chk("wpcir",    32'(bus.wpcir),    32'(!stall));
        chk("dbubble",  32'(bus.dbubble),  32'(stall));
        chk("md_start", 32'(bus.md_start), 32'(m_issue));
        chk("md_busy",  32'(bus.md_busy),  32'(busy));
        chk("md_done",  32'(bus.md_done),  32'(done));
        chk("md_count", 32'(bus.md_count), 32'(cnt));
`ifdef STALL_STATS_EN
        chk("lu_stall_cnt", bus.lu_stall_cnt, 32'(lu_m));
        chk("md_stall_cnt", bus.md_stall_cnt, 32'(md_m));
`endif
        if (abort_watch && bus.md_done) done_seen++;
    end

    always @(posedge clock) begin
        if (!resetn) begin
            issue_cyc = -1000;
            lu_m = 0;
            md_m = 0;
        end else begin
            if (m_issue) begin
                issue_cyc = cyc;
                issue_n   = bus.id_md_div ? DIV_N : MUL_N;
            end
            if (m_lu) lu_m++;
            if (m_md) md_m++;
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
        bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.ern = 5'd0; bus.ewreg = 1'b0; bus.em2reg = 1'b0;
        bus.id_md = 1'b0; bus.id_md_div = 1'b0; bus.id_hilo_rd = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        resetn = 1'b0;
        // Reset with a would-be hazard and md op present
        bus.ern = 5'd5; bus.ewreg = 1'b1; bus.em2reg = 1'b1;
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1; bus.id_md = 1'b1;
        #2;
        chk("rst_wpcir",    32'(bus.wpcir),    32'd1);
        chk("rst_dbubble",  32'(bus.dbubble),  32'd0);
        chk("rst_md_start", 32'(bus.md_start), 32'd0);
        chk("rst_md_busy",  32'(bus.md_busy),  32'd0);
        chk("rst_md_count", 32'(bus.md_count), 32'd0);
        tick(2);
        clear_inputs();
        resetn = 1'b1;
        tick(1);

        // Load-use on rt, one-cycle stall
        bus.ern = 5'd5; bus.ewreg = 1'b1; bus.em2reg = 1'b1;
        bus.id_rt = 5'd5; bus.id_use_rt = 1'b1;
        #1;
        chk("lu_wpcir",   32'(bus.wpcir),   32'd0);
        chk("lu_dbubble", 32'(bus.dbubble), 32'd1);
        tick(1);
        bus.ern = 5'd0; bus.ewreg = 1'b0; bus.em2reg = 1'b0;
        #1;
        chk("lu_release", 32'(bus.wpcir), 32'd1);
        tick(1);
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.id_rt = 5'd0;
        #1;
        chk("lu_r0_nostall", 32'(bus.wpcir), 32'd1);
        tick(1);
        clear_inputs();
        tick(1);

        // Multiply: count 4..1 then DONE then IDLE
        bus.id_md = 1'b1;
        #1;
        chk("mul_start", 32'(bus.md_start), 32'd1);
        tick(1);
        bus.id_md = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mul_busy",  32'(bus.md_busy),  32'd1);
            chk("mul_count", 32'(bus.md_count), 32'(4 - i));
            tick(1);
        end
        chk("mul_done", 32'(bus.md_done), 32'd1);
        tick(1);
        chk("mul_idle", 32'(bus.md_busy | bus.md_done), 32'd0);

        // Divide then mfhi: stall until DONE
        bus.id_md = 1'b1; bus.id_md_div = 1'b1;
        tick(1);
        bus.id_md = 1'b0; bus.id_md_div = 1'b0; bus.id_hilo_rd = 1'b1;
        #1;
        chk("hilo_stall", 32'(bus.wpcir), 32'd0);
        tick(31);
        chk("hilo_last_stall", 32'(bus.wpcir), 32'd0);
        chk("hilo_last_count", 32'(bus.md_count), 32'd1);
        tick(1);
        chk("hilo_done_go", 32'(bus.wpcir), 32'd1);
        chk("hilo_done",    32'(bus.md_done), 32'd1);
        clear_inputs();
        tick(1);

        // Back-to-back multiplies: reload in DONE without IDLE
        bus.id_md = 1'b1;
        tick(1);
        #1;
        chk("b2b_stall", 32'(bus.dbubble),  32'd1);
        chk("b2b_nostart", 32'(bus.md_start), 32'd0);
        tick(4);
        chk("b2b_start_done", 32'(bus.md_start), 32'd1);
        chk("b2b_go", 32'(bus.wpcir), 32'd1);
        tick(1);
        bus.id_md = 1'b0;
        #1;
        chk("b2b_reload", 32'(bus.md_count), 32'd4);
        tick(6);

        // Load-use blocks issue, op issues once the load has left EX
        bus.id_md = 1'b1; bus.id_rs = 5'd7; bus.id_use_rs = 1'b1;
        bus.ern = 5'd7; bus.ewreg = 1'b1; bus.em2reg = 1'b1;
        #1;
        chk("lu_blk_start", 32'(bus.md_start), 32'd0);
        chk("lu_blk_bubble", 32'(bus.dbubble), 32'd1);
        tick(1);
        bus.ern = 5'd0; bus.ewreg = 1'b0; bus.em2reg = 1'b0;
        #1;
        chk("lu_blk_issue", 32'(bus.md_start), 32'd1);
        tick(1);
        // Both hazards together during BUSY give one ordinary stall
        bus.ern = 5'd7; bus.ewreg = 1'b1; bus.em2reg = 1'b1;
        #1;
        chk("dual_bubble", 32'(bus.dbubble), 32'd1);
        tick(1);
        clear_inputs();
        tick(6);

        // Abort a divide with reset at count 10
        bus.id_md = 1'b1; bus.id_md_div = 1'b1;
        tick(1);
        clear_inputs();
        tick(22);
        chk("abort_pre", 32'(bus.md_count), 32'd10);
        @(negedge clock);
        #1;
        abort_watch = 1'b1;
        resetn = 1'b0;
        #1;
        chk("abort_busy",  32'(bus.md_busy),  32'd0);
        chk("abort_count", 32'(bus.md_count), 32'd0);
        chk("abort_wpcir", 32'(bus.wpcir),    32'd1);
`ifdef STALL_STATS_EN
        chk("abort_lu_cnt", bus.lu_stall_cnt, 32'd0);
        chk("abort_md_cnt", bus.md_stall_cnt, 32'd0);
`endif
        tick(2);
        resetn = 1'b1;
        tick(40);
        chk("abort_no_done", 32'(done_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
